// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcode and
// funct constants, and the ALUOp / PCSource / ALUSrcB select codes.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned PCSRC_W  = 2;
  localparam int unsigned SRCB_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RST        = 4'd0,
    ST_FETCH      = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_DECODE     = 4'd3,
    ST_R_EXEC     = 4'd4,
    ST_R_WB       = 4'd5,
    ST_ADDI_EXEC  = 4'd6,
    ST_ADDI_WB    = 4'd7,
    ST_MEM_ADDR   = 4'd8,
    ST_LW_READ    = 4'd9,
    ST_LW_WAIT    = 4'd10,
    ST_LW_WB      = 4'd11,
    ST_SW_WRITE   = 4'd12,
    ST_BRANCH     = 4'd13,
    ST_JUMP       = 4'd14,
    ST_HALT       = 4'd15
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type funct field (IR[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_XOR = 6'h26;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b101;

  // PC source mux
  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand mux
  localparam logic [SRCB_W-1:0] SRCB_B      = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/alu_control.sv
// ALU operation decoder: maps (FSM state, funct) to ALUOp and flags funct
// encodings outside the supported R-type subset. Purely combinational.
//   state         - current control FSM state
//   funct         - IR[5:0]
//   alu_op        - ALU operation for this state
//   funct_illegal - funct is not add/sub/and/xor
module alu_control
  import cpu_ctrl_pkg::*;
(
  input  state_t             state,
  input  logic [5:0]         funct,
  output logic [2:0]         alu_op,
  output logic               funct_illegal
);

  logic [ALUOP_W-1:0] rtype_op;

  // Decode funct independently of state so DECODE can use the illegal flag
  always_comb begin
    rtype_op      = ALU_ADD;
    funct_illegal = 1'b1;
    case (funct)
      FN_ADD: begin rtype_op = ALU_ADD; funct_illegal = 1'b0; end
      FN_SUB: begin rtype_op = ALU_SUB; funct_illegal = 1'b0; end
      FN_AND: begin rtype_op = ALU_AND; funct_illegal = 1'b0; end
      FN_XOR: begin rtype_op = ALU_XOR; funct_illegal = 1'b0; end
      default: ;
    endcase
  end

  // Only R_EXEC follows funct; branches compare by subtraction; all else adds
  always_comb begin
    alu_op = ALU_ADD;
    if (state == ST_R_EXEC) begin
      alu_op = rtype_op;
    end else if (state == ST_BRANCH) begin
      alu_op = ALU_SUB;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle CPU control FSM. Sequences PC, memory, IR, register file, A/B,
// MDR and ALUOut enables and all datapath mux selects for the add/sub/and/xor,
// addi, lw, sw, beq, bne and j subset; any other encoding halts.
//   clock, reset (async, active-low)
//   OPCODE, FUNCT - instruction fields from IR; zero - ALU zero flag
//   PCWrite/PCSource, IorD, MemWrite, IRWrite, MDRWrite, ABWrite, ALUOutWrite,
//   RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp - datapath controls
//   halted - machine is in HALT
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       zero,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       halted
);

  state_t state_q, state_d;
  // Instruction flavour captured in DECODE so later states never look at IR
  logic   is_bne_q, is_bne_d;
  logic   is_sw_q,  is_sw_d;
  logic   funct_illegal;

  alu_control u_alu_control (
    .state         (state_q),
    .funct         (FUNCT),
    .alu_op        (ALUOp),
    .funct_illegal (funct_illegal)
  );

  // State and decode-flag registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RST;
      is_bne_q <= 1'b0;
      is_sw_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_bne_q <= is_bne_d;
      is_sw_q  <= is_sw_d;
    end
  end

  // Next state and Moore outputs; PCWrite in BRANCH also follows zero
  always_comb begin
    state_d     = state_q;
    is_bne_d    = is_bne_q;
    is_sw_d     = is_sw_q;
    PCWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MDRWrite    = 1'b0;
    ABWrite     = 1'b0;
    ALUOutWrite = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    halted      = 1'b0;

    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = 1'b1;
        PCWrite  = 1'b1;
        PCSource = PCSRC_ALU;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        ALUSrcB     = SRCB_IMM_SH;
        ABWrite     = 1'b1;
        ALUOutWrite = 1'b1;
        is_bne_d    = (OPCODE == OP_BNE);
        is_sw_d     = (OPCODE == OP_SW);
        case (OPCODE)
          OP_RTYPE:     state_d = funct_illegal ? ST_HALT : ST_R_EXEC;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_HALT;
        endcase
      end
      ST_R_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALUOutWrite = 1'b1;
        state_d     = ST_R_WB;
      end
      ST_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_ADDI_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUOutWrite = 1'b1;
        state_d     = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUOutWrite = 1'b1;
        state_d     = is_sw_q ? ST_SW_WRITE : ST_LW_READ;
      end
      ST_LW_READ: begin
        IorD    = 1'b1;
        state_d = ST_LW_WAIT;
      end
      ST_LW_WAIT: begin
        IorD     = 1'b1;
        MDRWrite = 1'b1;
        state_d  = ST_LW_WB;
      end
      ST_LW_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_SW_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_B;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = is_bne_q ? ~zero : zero;
        state_d  = ST_FETCH;
      end
      ST_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: walks each instruction class through
// its state sequence and compares the full control vector every cycle.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  logic       clock, reset, zero;
  logic [5:0] OPCODE, FUNCT;
  logic       PCWrite, IorD, MemWrite, IRWrite, MDRWrite, ABWrite, ALUOutWrite;
  logic       RegWrite, RegDst, MemtoReg, ALUSrcA, halted;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;

  int tests_run    = 0;
  int tests_failed = 0;

  control_unit dut (
    .clock(clock), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .zero(zero),
    .PCWrite(PCWrite), .PCSource(PCSource), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MDRWrite(MDRWrite), .ABWrite(ABWrite),
    .ALUOutWrite(ALUOutWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .halted(halted)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // {PCWrite,PCSource,IorD,MemWrite,IRWrite,MDRWrite,ABWrite,ALUOutWrite,
  //  RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp}
  logic [17:0] outs;
  assign outs = {PCWrite, PCSource, IorD, MemWrite, IRWrite, MDRWrite, ABWrite,
                 ALUOutWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp};
  logic [6:0] enables;
  assign enables = {PCWrite, MemWrite, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite};

  localparam logic [17:0] V_RST   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001};
  localparam logic [17:0] V_FETCH = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001};
  localparam logic [17:0] V_FWAIT = {1'b1,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001};
  localparam logic [17:0] V_DEC   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b11,3'b001};
  localparam logic [17:0] V_RSUB  = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010};
  localparam logic [17:0] V_RWB   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,3'b001};
  localparam logic [17:0] V_IEXEC = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b10,3'b001};
  localparam logic [17:0] V_IWB   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b001};
  localparam logic [17:0] V_LRD   = {1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001};
  localparam logic [17:0] V_LWT   = {1'b0,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001};
  localparam logic [17:0] V_LWB   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b001};
  localparam logic [17:0] V_SW    = {1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001};
  localparam logic [17:0] V_BRT   = {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010};
  localparam logic [17:0] V_BRN   = {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010};
  localparam logic [17:0] V_JUMP  = {1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold reset two cycles, release, land on FETCH
  task automatic reset_to_fetch();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; OPCODE = OP_ADDI; FUNCT = 6'h00; zero = 1'b0;
    #2 reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if (dut.state_q !== ST_RST) begin
      tests_failed++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_RST);
    end
    tests_run++;
    if (outs !== V_RST || halted !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outs: got %b halted=%b want %b halted=0", outs, halted, V_RST);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (dut.state_q !== ST_FETCH) begin
      tests_failed++; $display("FAIL first_fetch: got %0d want %0d", dut.state_q, ST_FETCH);
    end
  endtask

  task automatic test_addi();
    state_t es [5];
    logic [17:0] ev [5];
    int pcw_cnt = 0;
    es = '{ST_FETCH, ST_FETCH_WAIT, ST_DECODE, ST_ADDI_EXEC, ST_ADDI_WB};
    ev = '{V_FETCH, V_FWAIT, V_DEC, V_IEXEC, V_IWB};
    OPCODE = OP_ADDI;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (dut.state_q !== es[i] || outs !== ev[i]) begin
        tests_failed++;
        $display("FAIL addi_cyc%0d: got st=%0d outs=%b want st=%0d outs=%b", i+1, dut.state_q, outs, es[i], ev[i]);
      end
      pcw_cnt = pcw_cnt + int'(PCWrite);
      tick();
    end
    tests_run++;
    if (dut.state_q !== ST_FETCH) begin
      tests_failed++; $display("FAIL addi_cpi: got %0d want %0d", dut.state_q, ST_FETCH);
    end
    tests_run++;
    if (pcw_cnt !== 1) begin
      tests_failed++; $display("FAIL addi_pcwrite_count: got %0d want 1", pcw_cnt);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [4];
    logic [2:0] op [4];
    state_t es [5];
    logic [17:0] ev [5];
    fn = '{FN_SUB, FN_ADD, FN_AND, FN_XOR};
    op = '{3'b010, 3'b001, 3'b011, 3'b101};
    es = '{ST_FETCH, ST_FETCH_WAIT, ST_DECODE, ST_R_EXEC, ST_R_WB};
    for (int k = 0; k < 4; k++) begin
      ev = '{V_FETCH, V_FWAIT, V_DEC, {V_RSUB[17:3], op[k]}, V_RWB};
      OPCODE = OP_RTYPE; FUNCT = fn[k];
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (dut.state_q !== es[i] || outs !== ev[i]) begin
          tests_failed++;
          $display("FAIL rtype_fn%h_cyc%0d: got st=%0d outs=%b want st=%0d outs=%b", fn[k], i+1, dut.state_q, outs, es[i], ev[i]);
        end
        tick();
      end
      tests_run++;
      if (dut.state_q !== ST_FETCH) begin
        tests_failed++; $display("FAIL rtype_cpi: got %0d want %0d", dut.state_q, ST_FETCH);
      end
    end
    FUNCT = 6'h00;
  endtask

  task automatic test_lw();
    state_t es [7];
    logic [17:0] ev [7];
    es = '{ST_FETCH, ST_FETCH_WAIT, ST_DECODE, ST_MEM_ADDR, ST_LW_READ, ST_LW_WAIT, ST_LW_WB};
    ev = '{V_FETCH, V_FWAIT, V_DEC, V_IEXEC, V_LRD, V_LWT, V_LWB};
    OPCODE = OP_LW;
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (dut.state_q !== es[i] || outs !== ev[i]) begin
        tests_failed++;
        $display("FAIL lw_cyc%0d: got st=%0d outs=%b want st=%0d outs=%b", i+1, dut.state_q, outs, es[i], ev[i]);
      end
      tick();
    end
    tests_run++;
    if (dut.state_q !== ST_FETCH) begin
      tests_failed++; $display("FAIL lw_cpi: got %0d want %0d", dut.state_q, ST_FETCH);
    end
  endtask

  task automatic test_branch();
    logic [5:0] opc [4];
    logic       z   [4];
    logic [17:0] vb [4];
    opc = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    z   = '{1'b1, 1'b0, 1'b0, 1'b1};
    vb  = '{V_BRT, V_BRN, V_BRT, V_BRN};
    for (int k = 0; k < 4; k++) begin
      OPCODE = opc[k]; zero = z[k];
      tick(); tick(); tick();
      tests_run++;
      if (dut.state_q !== ST_BRANCH || outs !== vb[k]) begin
        tests_failed++;
        $display("FAIL branch_op%h_z%b: got st=%0d outs=%b want st=%0d outs=%b", opc[k], z[k], dut.state_q, outs, ST_BRANCH, vb[k]);
      end
      // PCWrite must follow zero combinationally within the BRANCH cycle
      zero = ~z[k];
      #1;
      tests_run++;
      if (PCWrite !== ~vb[k][17]) begin
        tests_failed++; $display("FAIL branch_zero_comb%0d: got %b want %b", k, PCWrite, ~vb[k][17]);
      end
      zero = 1'b0;
      tick();
      tests_run++;
      if (dut.state_q !== ST_FETCH) begin
        tests_failed++; $display("FAIL branch_cpi%0d: got %0d want %0d", k, dut.state_q, ST_FETCH);
      end
    end
  endtask

  task automatic test_jump();
    OPCODE = OP_J;
    tick(); tick(); tick();
    tests_run++;
    if (dut.state_q !== ST_JUMP || outs !== V_JUMP) begin
      tests_failed++; $display("FAIL jump: got st=%0d outs=%b want st=%0d outs=%b", dut.state_q, outs, ST_JUMP, V_JUMP);
    end
    tick();
    tests_run++;
    if (dut.state_q !== ST_FETCH) begin
      tests_failed++; $display("FAIL jump_cpi: got %0d want %0d", dut.state_q, ST_FETCH);
    end
  endtask

  task automatic test_halt();
    logic [5:0] opc [2];
    logic [5:0] fn  [2];
    int bad;
    opc = '{6'h3F, OP_RTYPE};
    fn  = '{6'h20, 6'h07};
    for (int k = 0; k < 2; k++) begin
      OPCODE = opc[k]; FUNCT = fn[k];
      tick(); tick(); tick();
      tests_run++;
      if (dut.state_q !== ST_HALT) begin
        tests_failed++; $display("FAIL halt_entry%0d: got %0d want %0d", k, dut.state_q, ST_HALT);
      end
      // Legal encodings now present must not wake the machine
      OPCODE = OP_ADDI; FUNCT = FN_ADD;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        if (halted !== 1'b1 || enables !== 7'b0 || dut.state_q !== ST_HALT) bad++;
        tick();
      end
      tests_run++;
      if (bad !== 0) begin
        tests_failed++; $display("FAIL halt_hold%0d: got %0d bad cycles want 0", k, bad);
      end
      reset_to_fetch();
      tests_run++;
      if (dut.state_q !== ST_FETCH || halted !== 1'b0) begin
        tests_failed++; $display("FAIL halt_recover%0d: got st=%0d halted=%b want st=%0d halted=0", k, dut.state_q, halted, ST_FETCH);
      end
    end
    FUNCT = 6'h00;
  endtask

  task automatic test_sw_reset();
    OPCODE = OP_SW;
    tick(); tick(); tick(); tick();
    tests_run++;
    if (dut.state_q !== ST_SW_WRITE || outs !== V_SW) begin
      tests_failed++; $display("FAIL sw_write: got st=%0d outs=%b want st=%0d outs=%b", dut.state_q, outs, ST_SW_WRITE, V_SW);
    end
    tick();
    tests_run++;
    if (dut.state_q !== ST_FETCH) begin
      tests_failed++; $display("FAIL sw_cpi: got %0d want %0d", dut.state_q, ST_FETCH);
    end
    // Second store, aborted by reset in the middle of SW_WRITE
    tick(); tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (MemWrite !== 1'b0 || dut.state_q !== ST_RST || outs !== V_RST) begin
      tests_failed++; $display("FAIL sw_reset_abort: got MemWrite=%b st=%0d outs=%b want 0 st=%0d outs=%b", MemWrite, dut.state_q, outs, ST_RST, V_RST);
    end
    tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if (dut.state_q !== ST_FETCH || outs !== V_FETCH) begin
      tests_failed++; $display("FAIL sw_reset_resume: got st=%0d outs=%b want st=%0d outs=%b", dut.state_q, outs, ST_FETCH, V_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_lw();
    test_branch();
    test_jump();
    test_halt();
    test_sw_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM for the CPU datapath. Consumes OPCODE and funct from the instruction register and the ALU zero flag, and sequences every datapath write enable and mux select: PC, memory, IR, register file, A/B, MDR and ALUOut. Supported subset: R-type add/sub/and/xor, addi, lw, sw, beq, bne, j. Any other encoding halts the machine.

## Interface
- No parameters; all encodings are fixed in the shared package.
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low
- OPCODE  input  6  IR[31:26]
- FUNCT  input  6  IR[5:0]; meaningful only when OPCODE=0
- zero  input  1  ALU zero flag, combinational from the current ALU inputs
- PCWrite  output  1  PC load enable, already resolved for branches
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  output  1  memory address select: 0 PC, 1 ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR load enable
- MDRWrite, ABWrite, ALUOutWrite  output  1 each  latch enables
- RegWrite  output  1  register file write
- RegDst  output  1  write address: 0 rt, 1 rd
- MemtoReg  output  1  write data: 0 ALUOut, 1 MDR
- ALUSrcA  output  1  0 PC, 1 A
- ALUSrcB  output  2  00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
- ALUOp  output  3  001 add, 010 sub, 011 and, 101 xor
- halted  output  1  high while in HALT

## Operation
- States: RST, FETCH, FETCH_WAIT, DECODE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, MEM_ADDR, LW_READ, LW_WAIT, LW_WB, SW_WRITE, BRANCH, JUMP, HALT.
- RST → FETCH unconditionally.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add.
- FETCH_WAIT: same selects as FETCH, plus IRWrite=1, PCWrite=1, PCSource=00. PC becomes PC+4.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add, ABWrite=1, ALUOutWrite=1. ALUOut receives the branch target.
- DECODE dispatch:
  - 0x00 with a legal funct → R_EXEC
  - 0x08 → ADDI_EXEC
  - 0x23 and 0x2B → MEM_ADDR
  - 0x04 and 0x05 → BRANCH
  - 0x02 → JUMP
  - anything else → HALT
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp from funct (0x20 add, 0x22 sub, 0x24 and, 0x26 xor), ALUOutWrite=1 → R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, add, ALUOutWrite=1 → ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add, ALUOutWrite=1 → LW_READ for lw, SW_WRITE for sw.
- LW_READ: IorD=1 → LW_WAIT.
- LW_WAIT: IorD=1, MDRWrite=1 → LW_WB.
- LW_WB: RegWrite=1, RegDst=0, MemtoReg=1 → FETCH.
- SW_WRITE: IorD=1, MemWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01. PCWrite = zero for beq, ~zero for bne → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- HALT: all enables 0, halted=1. Stays in HALT until reset.

## Timing
- Reset: state=RST; every output 0 except ALUOp=001; halted=0. Reset acts immediately, including mid-instruction; a write strobe active at assertion drops the same instant.
- Outputs are Moore, decoded from the state register. The single exception is PCWrite in BRANCH, which also depends on zero combinationally.
- Cycles per instruction, FETCH to the next FETCH:
  - R-type and addi: 5
  - lw: 7
  - sw: 5
  - beq/bne: 4
  - j: 4
- The first FETCH occurs one cycle after reset deasserts.
- OPCODE and FUNCT are sampled only in DECODE and R_EXEC; IR is stable from FETCH_WAIT onward.
- No enable is ever high for more than one cycle per state visit. MemWrite and RegWrite are never high together.

## Structure
- Package cpu_ctrl_pkg holds:
  - the state enum
  - opcode and funct constants
  - ALUOp, PCSource and ALUSrcB codes
- Sub-module alu_control maps (state, FUNCT) to ALUOp. It is purely combinational and flags an illegal funct to the FSM.

## Test plan
- reset low, then high; OPCODE=0x08 → state sequence RST, FETCH, FETCH_WAIT, DECODE, ADDI_EXEC, ADDI_WB. PCWrite pulses exactly once, in FETCH_WAIT.
- OPCODE=0, FUNCT=0x22 → ALUOp=010 in R_EXEC. RegWrite=1, RegDst=1 in R_WB, which is cycle 5.
- OPCODE=0x23 → IorD=1 in LW_READ and LW_WAIT; MDRWrite in LW_WAIT; MemtoReg=1, RegWrite=1 in cycle 7.
- OPCODE=0x04 with zero=1 → PCWrite=1, PCSource=01 in BRANCH. Repeat with zero=0 → PCWrite=0. Repeat with OPCODE=0x05, zero=0 → PCWrite=1.
- OPCODE=0x3F, or OPCODE=0 with FUNCT=0x07 → HALT after DECODE; halted=1 and all enables 0 for 20 cycles.
- Assert reset during SW_WRITE → MemWrite drops immediately and state=RST. After release, FETCH resumes.
